// File: rtl/masar_div.sv
// masar_div: 16-bit by 8-bit unsigned restoring divider.
//
// One quotient bit is produced per cycle, MSB first, over 16 BUSY cycles.
// With the MASAR_DIV_EARLY_EXIT_EN macro defined, a zero divisor skips BUSY
// and the result is ready on the accept edge. With the macro undefined
// (default build), a zero divisor runs all 16 steps. The result values are
// the same in both builds.
//
// Ports:
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     dividend/divisor valid
//   in_ready     block can accept an operation (high exactly in IDLE)
//   dividend     16-bit unsigned dividend, sampled on accept
//   divisor      8-bit unsigned divisor, sampled on accept
//   out_valid    result valid (high exactly in DONE)
//   out_ready    consumer takes the result
//   quotient     16-bit registered quotient
//   remainder    8-bit registered remainder
//   div_by_zero  result came from a zero divisor
//   dbg_state    current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds its data until then. ready never depends
// on valid. in_ready and out_valid are decoded from the state alone.

module masar_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        div_by_zero,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    // Dividend bits shift out of the top while quotient bits shift in at the
    // bottom, so after 16 steps this register holds the quotient.
    logic [15:0] work;
    logic [7:0]  dvs;
    logic [7:0]  prem;
    logic [8:0]  shifted;
    logic [7:0]  prem_nxt;
    logic        qbit;
    logic        accept;
    logic        last_step;
    logic        early_zero;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign dbg_state = state;
    assign accept    = in_valid && in_ready;
    assign last_step = (cnt == 4'd15);

`ifdef MASAR_DIV_EARLY_EXIT_EN
    assign early_zero = accept && (divisor == 8'd0);
`else
    assign early_zero = 1'b0;
`endif

    // The partial remainder is 9 bits wide while the next dividend bit is
    // shifted in. After a successful subtract it is below the divisor, so it
    // fits in 8 bits. Only the low byte of the difference is needed.
    assign shifted  = {prem, work[15]};
    assign qbit     = (shifted >= {1'b0, dvs});
    assign prem_nxt = qbit ? (shifted[7:0] - dvs) : shifted[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = early_zero ? DONE : BUSY;
            BUSY: if (last_step) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= 4'd0;
            work        <= 16'd0;
            dvs         <= 8'd0;
            prem        <= 8'd0;
            quotient    <= 16'd0;
            remainder   <= 8'd0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt  <= 4'd0;
            work <= dividend;
            dvs  <= divisor;
            prem <= 8'd0;
            if (early_zero) begin
                quotient    <= 16'hFFFF;
                remainder   <= dividend[7:0];
                div_by_zero <= 1'b1;
            end
        end else if (state == BUSY) begin
            cnt  <= cnt + 4'd1;
            work <= {work[14:0], qbit};
            prem <= prem_nxt;
            // A zero divisor needs no special case here. Every trial subtract
            // succeeds, which gives an all-ones quotient. The remainder ends
            // up as the last eight dividend bits shifted in.
            if (last_step) begin
                quotient    <= {work[14:0], qbit};
                remainder   <= prem_nxt;
                div_by_zero <= (dvs == 8'd0);
            end
        end
    end

endmodule

// File: tb/tb_masar_div.sv
module tb_masar_div;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic [1:0]  dbg_state;

    int n_tests;
    int n_fail;

`ifdef MASAR_DIV_EARLY_EXIT_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 17;
`endif

    masar_div dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver. It returns at a negedge with the DUT back in IDLE.
    // lat counts rising edges from the accept edge (edge 1) until out_valid
    // is seen. dup reports out_valid still high after the result was taken.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b, input int stall,
                          output logic [15:0] q, output logic [7:0] r, output logic z,
                          output int lat, output logic dup, output logic tmo);
        int guard;
        tmo   = 1'b0;
        dup   = 1'b0;
        q     = '0;
        r     = '0;
        z     = 1'b0;
        lat   = 0;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            tmo = 1'b1;
            return;
        end
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid) begin
            tmo = 1'b1;
            return;
        end
        q = quotient;
        r = remainder;
        z = div_by_zero;
        repeat (stall) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        dup = out_valid;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #12;
        n_tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_hs: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        n_tests++;
        if ({quotient, remainder, div_by_zero} !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_out: got q=%h r=%h z=%b, want 0 0 0", quotient, remainder, div_by_zero);
        end
        n_tests++;
        if (dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d, want 0", dbg_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_divide();
        logic [15:0] va[8]  = '{16'd1000, 16'hFFFF, 16'd5, 16'd200, 16'hFFFF, 16'd0, 16'd255, 16'd65535};
        logic [7:0]  vb[8]  = '{8'd7, 8'hFF, 8'd9, 8'd3, 8'd1, 8'd5, 8'd255, 8'd2};
        logic [15:0] vq[8]  = '{16'd142, 16'd257, 16'd0, 16'd66, 16'hFFFF, 16'd0, 16'd1, 16'd32767};
        logic [7:0]  vr[8]  = '{8'd6, 8'd0, 8'd5, 8'd2, 8'd0, 8'd0, 8'd0, 8'd1};
        logic [15:0] q;
        logic [7:0]  r;
        logic        z, dup, tmo;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            run_op(va[i], vb[i], i % 3, q, r, z, lat, dup, tmo);
            n_tests++;
            if (tmo || {q, r, z} !== {vq[i], vr[i], 1'b0}) begin
                n_fail++;
                $display("FAIL divide_%0d: %0d/%0d got q=%0d r=%0d z=%b tmo=%b, want q=%0d r=%0d z=0",
                         i, va[i], vb[i], q, r, z, tmo, vq[i], vr[i]);
            end
            n_tests++;
            if (lat != 17 || dup) begin
                n_fail++;
                $display("FAIL divide_lat_%0d: got lat=%0d dup=%b, want 17 0", i, lat, dup);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [15:0] q;
        logic [7:0]  r;
        logic        z, dup, tmo;
        int          lat;
        run_op(16'h1234, 8'd0, 2, q, r, z, lat, dup, tmo);
        n_tests++;
        if (tmo || {q, r, z} !== {16'hFFFF, 8'h34, 1'b1}) begin
            n_fail++;
            $display("FAIL div_zero: got q=%h r=%h z=%b tmo=%b, want ffff 34 1", q, r, z, tmo);
        end
        n_tests++;
        if (lat != ZERO_LAT || dup) begin
            n_fail++;
            $display("FAIL div_zero_lat: got lat=%0d dup=%b, want %0d 0", lat, dup, ZERO_LAT);
        end
        run_op(16'd100, 8'd10, 0, q, r, z, lat, dup, tmo);
        n_tests++;
        if (tmo || {q, r, z} !== {16'd10, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL div_zero_clear: got q=%0d r=%0d z=%b, want 10 0 0", q, r, z);
        end
    endtask

    task automatic test_stall();
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 16'd1000;
        divisor  = 8'd7;
        @(posedge clk);
        @(negedge clk);
        while (!out_valid && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        for (int i = 0; i < 5; i++) begin
            dividend = 16'($urandom);
            divisor  = 8'($urandom);
            @(negedge clk);
            n_tests++;
            if ({out_valid, in_ready} !== 2'b10 || quotient !== 16'd142 || remainder !== 8'd6
                || div_by_zero !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got ov=%b ir=%b q=%0d r=%0d z=%b, want 1 0 142 6 0",
                         i, out_valid, in_ready, quotient, remainder, div_by_zero);
            end
        end
        // in_valid is still high across the taking edge, so nothing may be accepted there.
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        n_tests++;
        if (dbg_state !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: got state=%0d ov=%b ir=%b, want 0 0 1", dbg_state, out_valid, in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        logic [15:0] q;
        logic [7:0]  r;
        logic        z, dup, tmo;
        int          lat;
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 16'd1000;
        divisor  = 8'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        n_tests++;
        if (dbg_state !== 2'd1) begin
            n_fail++;
            $display("FAIL busy_before_reset: got state=%0d, want 1", dbg_state);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01 || {quotient, remainder, div_by_zero} !== 25'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got ov=%b ir=%b q=%0d r=%0d z=%b, want 0 1 0 0 0",
                     out_valid, in_ready, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'd200, 8'd3, 1, q, r, z, lat, dup, tmo);
        n_tests++;
        if (tmo || {q, r, z} !== {16'd66, 8'd2, 1'b0} || lat != 17) begin
            n_fail++;
            $display("FAIL after_reset: got q=%0d r=%0d z=%b lat=%0d, want 66 2 0 17", q, r, z, lat);
        end
    endtask

    // scoreboard fed by a reference model
    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        logic [15:0] a, q;
        logic [7:0]  b, r;
        logic        z, dup, tmo;
        logic [31:0] exp;
        int          lat, want_lat;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom_range(0, 65535));
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            if (b == 8'd0) exp_q.push_back({7'd0, 16'hFFFF, a[7:0], 1'b1});
            else           exp_q.push_back({7'd0, a / 16'(b), 8'(a % 16'(b)), 1'b0});
            want_lat = (b == 8'd0) ? ZERO_LAT : 17;
            run_op(a, b, $urandom_range(0, 3), q, r, z, lat, dup, tmo);
            exp = exp_q.pop_front();
            n_tests++;
            if (tmo || dup || lat != want_lat || {7'd0, q, r, z} !== exp) begin
                n_fail++;
                $display("FAIL b2b_%0d: %0d/%0d got q=%0d r=%0d z=%b lat=%0d dup=%b tmo=%b, want q=%0d r=%0d z=%b lat=%0d",
                         i, a, b, q, r, z, lat, dup, tmo, exp[24:9], exp[8:1], exp[0], want_lat);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_divide();
        test_div_zero();
        test_stall();
        test_reset_mid_busy();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
